// File: rtl/request_issuer.sv
// request_issuer
// Requester-side front end for a round-robin style arbiter. Each channel keeps a
// count of queued transactions from its local client, raises its request bit
// while that count is non-zero, and retires one transaction per accepted grant.
// It also flags starvation (request held without a grant for too long) and
// latches a sticky error when the arbiter breaks the grant protocol.
module request_issuer #(
    parameter  int REQUEST_WIDTH = 8,
    parameter  int MAX_PENDING   = 4,
    parameter  int STARVE_LIMIT  = 32,
    localparam int COUNT_WIDTH   = $clog2(MAX_PENDING + 1),
    localparam int WAIT_WIDTH    = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [REQUEST_WIDTH-1:0]             i_push,
    output logic [REQUEST_WIDTH-1:0]             o_push_ready,
    output logic [REQUEST_WIDTH-1:0]             o_request,
    input  logic [REQUEST_WIDTH-1:0]             i_grant,
    output logic [REQUEST_WIDTH*COUNT_WIDTH-1:0] o_pending_count,
    output logic [REQUEST_WIDTH-1:0]             o_starved,
    output logic                                 o_protocol_error
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_FULL  = COUNT_WIDTH'(MAX_PENDING);
    localparam logic [WAIT_WIDTH-1:0]  WAIT_LIMIT  = WAIT_WIDTH'(STARVE_LIMIT);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE   = COUNT_WIDTH'(1);
    localparam logic [WAIT_WIDTH-1:0]  WAIT_ONE    = WAIT_WIDTH'(1);

    // Per-channel state: queued transaction count and request-without-grant age.
    logic [COUNT_WIDTH-1:0] count_q  [REQUEST_WIDTH];
    logic [WAIT_WIDTH-1:0]  wait_cnt [REQUEST_WIDTH];
    logic                   protocol_error_q;

    logic [REQUEST_WIDTH-1:0] push_acc;
    logic [REQUEST_WIDTH-1:0] grant_ok;
    logic                     grant_onehot0;
    logic                     grant_unrequested;
    logic                     grant_violation;

    // Ready, request and starvation flags are pure decodes of the registered state,
    // so none of them has a combinational path from any input.
    for (genvar g = 0; g < REQUEST_WIDTH; g++) begin : g_chan_out
        assign o_push_ready[g] = (count_q[g] != COUNT_FULL);
        assign o_request[g]    = (count_q[g] != '0);
        assign o_starved[g]    = (wait_cnt[g] == WAIT_LIMIT);
        assign o_pending_count[g*COUNT_WIDTH +: COUNT_WIDTH] = count_q[g];
    end

    assign o_protocol_error = protocol_error_q;

    // Classify this cycle's grant vector; any violation suppresses every retirement
    // so a misbehaving arbiter cannot silently drop queued work.
    always_comb begin
        grant_onehot0     = ((i_grant & (i_grant - REQUEST_WIDTH'(1))) == '0);
        grant_unrequested = |(i_grant & ~o_request);
        grant_violation   = grant_unrequested | ~grant_onehot0;
        push_acc          = i_push & o_push_ready;
        grant_ok          = '0;
        if (!grant_violation) begin
            grant_ok = i_grant & o_request;
        end
    end

    // Queue depth per channel: +1 on accepted push, -1 on accepted grant, both cancel.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < REQUEST_WIDTH; i++) begin
            if (i_rst) begin
                count_q[i] <= '0;
            end else if (push_acc[i] && !grant_ok[i]) begin
                count_q[i] <= count_q[i] + COUNT_ONE;
            end else if (grant_ok[i] && !push_acc[i]) begin
                count_q[i] <= count_q[i] - COUNT_ONE;
            end
        end
    end

    // Starvation age: restarts on a grant or an empty queue, saturates at the limit.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < REQUEST_WIDTH; i++) begin
            if (i_rst) begin
                wait_cnt[i] <= '0;
            end else if (grant_ok[i] || (count_q[i] == '0)) begin
                wait_cnt[i] <= '0;
            end else if (o_request[i] && (wait_cnt[i] != WAIT_LIMIT)) begin
                wait_cnt[i] <= wait_cnt[i] + WAIT_ONE;
            end
        end
    end

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            protocol_error_q <= 1'b0;
        end else if (grant_violation) begin
            protocol_error_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_request_issuer.sv
// Directed testbench for request_issuer: reset, handshake, full queue,
// push/grant overlap, starvation timing and grant-protocol violations.
module tb_request_issuer;

    localparam int RW = 8;
    localparam int CW = 3;

    logic           i_clk;
    logic           i_rst;
    logic [RW-1:0]  i_push;
    logic [RW-1:0]  o_push_ready;
    logic [RW-1:0]  o_request;
    logic [RW-1:0]  i_grant;
    logic [RW*CW-1:0] o_pending_count;
    logic [RW-1:0]  o_starved;
    logic           o_protocol_error;

    int check_count;
    int error_count;

    request_issuer #(
        .REQUEST_WIDTH(RW),
        .MAX_PENDING  (4),
        .STARVE_LIMIT (32)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_push          (i_push),
        .o_push_ready    (o_push_ready),
        .o_request       (o_request),
        .i_grant         (i_grant),
        .o_pending_count (o_pending_count),
        .o_starved       (o_starved),
        .o_protocol_error(o_protocol_error)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
    task automatic applyStimulus(input logic [RW-1:0] push, input logic [RW-1:0] grant);
        i_push  = push;
        i_grant = grant;
        @(posedge i_clk);
        #1;
        i_push  = '0;
        i_grant = '0;
    endtask

    // Idle cycles with no push and no grant.
    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus('0, '0);
    endtask

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] chanCount(input int ch);
        return 32'(o_pending_count[ch*CW +: CW]);
    endfunction

    initial begin
        check_count = 0;
        error_count = 0;
        i_rst   = 1'b1;
        i_push  = '0;
        i_grant = '0;
        #1;
        idleCycles(2);
        i_rst = 1'b0;

        // Reset state
        checkOutput("rst_request",    32'(o_request),        32'h00);
        checkOutput("rst_ready",      32'(o_push_ready),     32'hFF);
        checkOutput("rst_counts",     32'(o_pending_count),  32'h0);
        checkOutput("rst_starved",    32'(o_starved),        32'h00);
        checkOutput("rst_perr",       32'(o_protocol_error), 32'h0);

        // Basic handshake on channel 3
        applyStimulus(8'h08, 8'h00);
        checkOutput("hs_request_up",  32'(o_request),        32'h08);
        checkOutput("hs_count3_one",  chanCount(3),          32'd1);
        applyStimulus(8'h00, 8'h08);
        checkOutput("hs_request_dn",  32'(o_request),        32'h00);
        checkOutput("hs_count3_zero", chanCount(3),          32'd0);
        checkOutput("hs_perr",        32'(o_protocol_error), 32'h0);

        // Full queue on channel 0
        for (int k = 0; k < 4; k++) applyStimulus(8'h01, 8'h00);
        checkOutput("full_count0",    chanCount(0),          32'd4);
        checkOutput("full_ready",     32'(o_push_ready),     32'hFE);
        applyStimulus(8'h01, 8'h00);
        checkOutput("full_drop",      chanCount(0),          32'd4);
        applyStimulus(8'h00, 8'h01);
        checkOutput("full_grant_cnt", chanCount(0),          32'd3);
        checkOutput("full_grant_rdy", 32'(o_push_ready),     32'hFF);
        for (int k = 0; k < 3; k++) applyStimulus(8'h00, 8'h01);
        checkOutput("full_drained",   32'(o_request),        32'h00);

        // Simultaneous push and grant on channel 5
        applyStimulus(8'h20, 8'h00);
        checkOutput("pg_count5_one",  chanCount(5),          32'd1);
        applyStimulus(8'h20, 8'h20);
        checkOutput("pg_count5_same", chanCount(5),          32'd1);
        checkOutput("pg_request5",    32'(o_request),        32'h20);
        applyStimulus(8'h00, 8'h20);
        checkOutput("pg_count5_zero", chanCount(5),          32'd0);

        // Starvation on channel 7: two queued so the request survives one grant
        applyStimulus(8'h80, 8'h00);
        applyStimulus(8'h80, 8'h00);
        idleCycles(30);
        checkOutput("starve_31",      32'(o_starved),        32'h00);
        idleCycles(1);
        checkOutput("starve_32",      32'(o_starved),        32'h80);
        idleCycles(1);
        checkOutput("starve_sat",     32'(o_starved),        32'h80);
        applyStimulus(8'h00, 8'h80);
        checkOutput("starve_clear",   32'(o_starved),        32'h00);
        checkOutput("starve_req",     32'(o_request),        32'h80);
        applyStimulus(8'h00, 8'h80);
        checkOutput("starve_empty",   chanCount(7),          32'd0);

        // Violations
        checkOutput("viol_pre_perr",  32'(o_protocol_error), 32'h0);
        applyStimulus(8'h00, 8'h04);
        checkOutput("viol_unreq",     32'(o_protocol_error), 32'h1);
        checkOutput("viol_unreq_cnt", 32'(o_pending_count),  32'h0);
        applyStimulus(8'h03, 8'h00);
        checkOutput("viol_two_req",   32'(o_pending_count),  32'h000009);
        applyStimulus(8'h00, 8'h03);
        checkOutput("viol_multi_cnt", 32'(o_pending_count),  32'h000009);
        checkOutput("viol_multi_req", 32'(o_request),        32'h03);
        idleCycles(3);
        checkOutput("viol_sticky",    32'(o_protocol_error), 32'h1);

        // Reset mid-operation discards queued work and clears the error
        i_rst = 1'b1;
        idleCycles(1);
        i_rst = 1'b0;
        checkOutput("rst2_perr",      32'(o_protocol_error), 32'h0);
        checkOutput("rst2_counts",    32'(o_pending_count),  32'h0);
        checkOutput("rst2_request",   32'(o_request),        32'h00);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
